// File: rtl/par_tdm_buffer.sv
// par_tdm_buffer: one FIFO per security partition, drained onto a single
// shared output by a fixed round-robin time-division schedule. The slot
// counter free-runs, so output timing for one channel never depends on the
// occupancy or traffic of any other channel.
module par_tdm_buffer #(
  parameter int NCH   = 4,
  parameter int DEPTH = 4,
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(NCH),
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NCH-1:0]          in_valid,
  output logic [NCH-1:0]          in_ready,
  input  logic [NCH*WIDTH-1:0]    in_data,
  input  logic [NCH-1:0]          out_ready,
  output logic                    out_valid,
  output logic [CW-1:0]           out_chan,
  output logic [WIDTH-1:0]        out_data,
  output logic [NCH*(AW+1)-1:0]   occ
);

  localparam logic [AW:0]   OCC_FULL  = (AW+1)'(DEPTH);
  localparam logic [CW-1:0] LAST_SLOT = CW'(NCH - 1);

  // Per-channel storage; channel i's entries, pointers and count are only
  // ever written from channel i's own inputs.
  logic [WIDTH-1:0] r_mem   [NCH][DEPTH];
  logic [AW-1:0]    r_wrPtr [NCH];
  logic [AW-1:0]    r_rdPtr [NCH];
  logic [AW:0]      r_occ   [NCH];
  logic [CW-1:0]    r_slot;

  logic [NCH-1:0]   w_push;
  logic [NCH-1:0]   w_pop;
  logic [NCH-1:0]   w_notFull;
  logic [WIDTH-1:0] w_headData;
  logic             w_popNow;

  // Per-channel handshake decode: not-full depends only on that channel's
  // count, and a pop is only possible in that channel's own slot.
  always_comb begin
    w_push    = '0;
    w_pop     = '0;
    w_notFull = '0;
    for (int i = 0; i < NCH; i++) begin
      w_notFull[i] = (r_occ[i] != OCC_FULL);
      w_push[i]    = in_valid[i] && w_notFull[i];
      w_pop[i]     = (r_slot == CW'(i)) && (r_occ[i] != '0) && out_ready[i];
    end
  end

  // Head of the channel owning the current slot, plus whether it pops now.
  always_comb begin
    w_headData = r_mem[r_slot][r_rdPtr[r_slot]];
    w_popNow   = w_pop[r_slot];
  end

  // Flatten per-channel counts onto the occupancy port.
  always_comb begin
    occ = '0;
    for (int i = 0; i < NCH; i++) begin
      occ[i*(AW+1) +: (AW+1)] = r_occ[i];
    end
  end

  assign in_ready = w_notFull;

  // Free-running slot counter, independent of every data-path signal.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_slot <= '0;
    end else if (r_slot == LAST_SLOT) begin
      r_slot <= '0;
    end else begin
      r_slot <= r_slot + CW'(1);
    end
  end

  // Channel FIFO state: pointers wrap at DEPTH, count tracks push minus pop
  // so simultaneous push and pop leaves the count unchanged.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NCH; i++) begin
        r_wrPtr[i] <= '0;
        r_rdPtr[i] <= '0;
        r_occ[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (w_push[i]) begin
          r_wrPtr[i] <= r_wrPtr[i] + AW'(1);
        end
        if (w_pop[i]) begin
          r_rdPtr[i] <= r_rdPtr[i] + AW'(1);
        end
        r_occ[i] <= r_occ[i] + (AW+1)'(w_push[i]) - (AW+1)'(w_pop[i]);
      end
    end
  end

  // Entry storage is not reset; discarded entries become unreachable once
  // the pointers and counts are cleared.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NCH; i++) begin
      if (!reset && w_push[i]) begin
        r_mem[i][r_wrPtr[i]] <= in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Registered output: the current slot index is always presented, and the
  // data is zeroed on idle slots so no partition's stale word lingers.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_chan  <= '0;
      out_data  <= '0;
    end else begin
      out_chan <= r_slot;
      if (w_popNow) begin
        out_valid <= 1'b1;
        out_data  <= w_headData;
      end else begin
        out_valid <= 1'b0;
        out_data  <= '0;
      end
    end
  end

endmodule
